acc_recv: RTL and testbench
===========================

Name: acc_recv

Overview:
- Receive-side counterpart of the accelerator send stage. Sits between the router egress and the Nios II custom-instruction and Avalon-MM interfaces.
- Consumes 128-bit packets. Eager messages and completed rendezvous transfers are queued in a match FIFO that the CPU reads.
- Rendezvous data words are written into main memory through an Avalon-MM write master.

Parameters:
- FIFO_AW, 3, log2 of match FIFO depth (depth 8 entries, 64 bits each).
- ADDR_W, 20, memory address width.
- NODE_ID, 8'd1, local node number. Used only with the optional feature.

Ports:
- nios_clk  in  1  clock
- reset  in  1  synchronous, active-high
- packet_in  in  128  router packet
- packet_in_valid  in  1  packet_in valid
- packet_in_ready  out  1  block accepts packet this cycle
- mem_addr  out  20  write address
- mem_wdata  out  32  write data
- write  out  1  Avalon write request
- waitrequest  in  1  Avalon stall
- clk_en  in  1  custom-instruction clock enable
- start  in  1  custom-instruction start
- in_opcode  in  3  CPU command
- result  out  32  CPU read data
- done  out  1  CPU command complete

Behaviour:
- Interface: reset reset, synchronous, active-high; clock nios_clk.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, drop_cnt and err cleared.
- Reset mid-transfer abandons the transfer. Any in-flight write is deasserted with no completion entry pushed.
- A packet transfers when packet_in_valid and packet_in_ready are both high.

Packet fields:
- kind = [127:123]; opcode = [122:120]; head = [119:88].
- EAGER (10000): payload = [87:56].
- RNDV_HDR (10001), DATA (11000), DATA_LAST (11001): size = [87:77], word = [76:45].
- Bits [44:0] are ignored.

FSM states: IDLE, STREAM, WR, CMPL.
- IDLE, EAGER accepted: push {head, payload} to the FIFO. Stay in IDLE.
- IDLE, RNDV_HDR accepted: latch head and size; base = word[19:0]; cnt = 0; go to STREAM.
  - If size == 0: go directly to CMPL.
- IDLE, DATA or DATA_LAST accepted: drop the packet. drop_cnt increments, saturating at 16'hFFFF.
- STREAM, DATA or DATA_LAST accepted:
  - mem_addr = base + cnt (modulo 2^20), mem_wdata = word, write = 1; go to WR.
- STREAM, EAGER or RNDV_HDR: drop the packet and count it in drop_cnt. State is unchanged.
- WR: hold write, mem_addr and mem_wdata stable while waitrequest = 1.
  - On the first cycle with waitrequest = 0: write drops next cycle and cnt increments.
  - If the word was DATA_LAST, or cnt == size-1: go to CMPL. Otherwise go to STREAM.
  - err is set if DATA_LAST arrives with cnt != size-1, or if cnt reaches size-1 on a non-last DATA.
- CMPL: push {head, 21'b0, size} to the FIFO; go to IDLE.

packet_in_ready:
- Low in WR and CMPL.
- Low in IDLE when the FIFO is full.
- High otherwise.

FIFO:
- A push when full is not possible: ready gates the EAGER push, and CMPL waits while the FIFO is full.
- A pop from an empty FIFO is ignored.
- A simultaneous push and pop in the same cycle leaves the count unchanged.

CPU command (clk_en & start sampled):
- done is a 1-cycle pulse on the following cycle, with result valid in that same cycle.
- done and result stay 0 otherwise.
- 000: result = front head, no pop.
- 001: result = front data word, then pop.
- 010: result = {drop_cnt[15:0], err, 11'b0, fifo_count[3:0]}.
- 011: clear err and drop_cnt.
- Other opcodes: result = 0.
- On an empty FIFO, 000 and 001 return 0.

Optional Feature:
- Macro: ACC_RECV_DST_CHECK_EN.
- When defined: for EAGER and RNDV_HDR packets, head[7:0] is compared with NODE_ID.
  - On a mismatch the packet is accepted, dropped and counted in drop_cnt, with no FIFO push and no state change.
  - A dropped RNDV_HDR leaves the following DATA packets to be dropped in IDLE.
- When undefined: no destination check; all well-formed packets are processed.

Test Plan:
1. EAGER, head 32'h55550001, payload 32'h0000ABCD; then CPU 000, then 001 -> results 32'h55550001 then 32'h0000ABCD; fifo_count back to 0.
2. RNDV_HDR size 3, word 32'h00000100; DATA 0x11, DATA 0x22, DATA_LAST 0x33; waitrequest held 2 cycles on the 2nd write -> writes 0x100=0x11, 0x101=0x22, 0x102=0x33 with address and data stable under stall; FIFO entry {head, 32'd3}; err = 0.
3. Send 9 EAGER packets with no CPU reads -> 8 accepted; packet_in_ready low with the 9th valid; one 001 pop -> 9th accepted next cycle.
4. DATA in IDLE, then RNDV_HDR size 2 followed by DATA_LAST -> drop_cnt = 1, err = 1, completion entry pushed; opcode 011 -> status reads 0 except fifo_count.
5. Reset asserted in WR with waitrequest = 1 -> write = 0, FIFO empty and all outputs 0 the cycle after reset.
6. With ACC_RECV_DST_CHECK_EN and NODE_ID = 1: EAGER with head[7:0] = 8'h02 -> no push, drop_cnt = 1; head[7:0] = 8'h01 -> pushed.

Source files
------------

// File: rtl/acc_recv_if.sv
// Router-egress, Avalon-MM write and custom-instruction signals of the receive stage.
// slave is the acc_recv side; master is the environment (router, memory, CPU).
interface acc_recv_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic [127:0]      packet_in;
  logic              packet_in_valid;
  logic              packet_in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              write;
  logic              waitrequest;
  logic              clk_en;
  logic              start;
  logic [2:0]        in_opcode;
  logic [31:0]       result;
  logic              done;

  modport slave (
    input  packet_in, packet_in_valid, waitrequest, clk_en, start, in_opcode,
    output packet_in_ready, mem_addr, mem_wdata, write, result, done
  );

  modport master (
    output packet_in, packet_in_valid, waitrequest, clk_en, start, in_opcode,
    input  packet_in_ready, mem_addr, mem_wdata, write, result, done
  );
endinterface

// File: rtl/acc_recv.sv
// Accelerator receive stage: eager/rendezvous completions into a CPU-read match FIFO,
// rendezvous data into memory. Optional destination filter: ACC_RECV_DST_CHECK_EN.
module acc_recv #(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned ADDR_W  = 20,
  parameter logic [7:0]  NODE_ID = 8'd1
) (
  input logic        nios_clk,
  input logic        reset,
  acc_recv_if.slave  bus
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

  localparam logic [4:0] KindEager = 5'b10000;
  localparam logic [4:0] KindRndv  = 5'b10001;
  localparam logic [4:0] KindData  = 5'b11000;
  localparam logic [4:0] KindLast  = 5'b11001;

  localparam logic [2:0] OpHead   = 3'b000;
  localparam logic [2:0] OpPop    = 3'b001;
  localparam logic [2:0] OpStatus = 3'b010;
  localparam logic [2:0] OpClear  = 3'b011;

`ifdef ACC_RECV_DST_CHECK_EN
  localparam bit DstCheckEn = 1'b1;
`else
  localparam bit DstCheckEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StStream, StWr, StCmpl} state_e;

  state_e state_q, state_d;

  logic [31:0]       head_q, head_d;
  logic [10:0]       size_q, size_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              err_q, err_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;

  logic [63:0]        fifo_mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   fifo_cnt_q;
  logic               fifo_full, fifo_empty;
  logic [63:0]        fifo_front;
  logic [3:0]         fifo_cnt4;

  logic        push, pop, drop, err_set, clear, cmd;
  logic [63:0] push_data;
  logic        ready, accept, dst_ok, at_end;

  logic [4:0]  pkt_kind;
  logic [31:0] pkt_head, pkt_payload, pkt_word;
  logic [10:0] pkt_size;

  assign pkt_kind    = bus.packet_in[127:123];
  assign pkt_head    = bus.packet_in[119:88];
  assign pkt_payload = bus.packet_in[87:56];
  assign pkt_size    = bus.packet_in[87:77];
  assign pkt_word    = bus.packet_in[76:45];

  logic unused_pkt_bits;
  assign unused_pkt_bits = ^{bus.packet_in[122:120], bus.packet_in[44:0]};

  assign fifo_full  = (fifo_cnt_q == DepthCnt);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_front = fifo_mem[rd_ptr_q];
  assign fifo_cnt4  = 4'(fifo_cnt_q);

  assign dst_ok = !DstCheckEn || (pkt_head[7:0] == NODE_ID);

  // No packet is taken while reset is held, so nothing is lost across it.
  assign bus.packet_in_ready = ready & ~reset;
  assign accept              = bus.packet_in_valid & bus.packet_in_ready;

  assign at_end = (cnt_q == size_q - 11'd1);

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    ready     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    drop      = 1'b0;
    err_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = !fifo_full;
        if (accept) begin
          case (pkt_kind)
            KindEager: begin
              if (dst_ok) begin
                push      = 1'b1;
                push_data = {pkt_head, pkt_payload};
              end else begin
                drop = 1'b1;
              end
            end
            KindRndv: begin
              if (dst_ok) begin
                head_d  = pkt_head;
                size_d  = pkt_size;
                base_d  = pkt_word[ADDR_W-1:0];
                cnt_d   = '0;
                state_d = (pkt_size == '0) ? StCmpl : StStream;
              end else begin
                drop = 1'b1;
              end
            end
            KindData, KindLast: drop = 1'b1;
            default: ;
          endcase
        end
      end
      StStream: begin
        ready = 1'b1;
        if (accept) begin
          case (pkt_kind)
            KindData, KindLast: begin
              addr_d  = base_q + ADDR_W'(cnt_q);
              wdata_d = pkt_word;
              write_d = 1'b1;
              last_d  = (pkt_kind == KindLast);
              state_d = StWr;
            end
            KindEager, KindRndv: drop = 1'b1;
            default: ;
          endcase
        end
      end
      StWr: begin
        if (!bus.waitrequest) begin
          write_d = 1'b0;
          cnt_d   = cnt_q + 11'd1;
          // Sender's last-marker and our own word count must agree.
          err_set = (last_q != at_end);
          state_d = (last_q || at_end) ? StCmpl : StStream;
        end
      end
      StCmpl: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = {head_q, 21'b0, size_q};
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd      = bus.clk_en & bus.start;
    pop      = cmd && (bus.in_opcode == OpPop) && !fifo_empty;
    clear    = cmd && (bus.in_opcode == OpClear);
    done_d   = cmd;
    result_d = '0;
    if (cmd) begin
      case (bus.in_opcode)
        OpHead:   result_d = fifo_empty ? 32'd0 : fifo_front[63:32];
        OpPop:    result_d = fifo_empty ? 32'd0 : fifo_front[31:0];
        OpStatus: result_d = {drop_cnt_q, err_q, 11'b0, fifo_cnt4};
        default:  result_d = '0;
      endcase
    end

    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    err_d = clear ? 1'b0 : (err_q | err_set);
  end

  always_ff @(posedge nios_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      head_q     <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
      result_q   <= result_d;
      done_q     <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge nios_clk) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.write     = write_q;
  assign bus.result    = result_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_acc_recv.sv
// Directed bench for acc_recv: expected CPU results and memory writes are queued
// when stimulus is driven and compared by monitors when the DUT produces them.
module tb_acc_recv;

  localparam logic [4:0] KEager = 5'b10000;
  localparam logic [4:0] KRndv  = 5'b10001;
  localparam logic [4:0] KData  = 5'b11000;
  localparam logic [4:0] KLast  = 5'b11001;

  logic nios_clk = 1'b0;
  logic reset;

  always #5 nios_clk = ~nios_clk;

  acc_recv_if #(.ADDR_W(20)) bus ();

  acc_recv #(
    .FIFO_AW(3),
    .ADDR_W (20),
    .NODE_ID(8'd1)
  ) dut (
    .nios_clk(nios_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int vectors = 0;
  int misses  = 0;

  logic [31:0] cpu_q [$];
  logic [51:0] wr_q  [$];

  logic        stall_seen = 1'b0;
  logic [19:0] held_addr  = '0;
  logic [31:0] held_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] eager(input logic [31:0] head, input logic [31:0] payload);
    return {KEager, 3'b000, head, payload, 56'b0};
  endfunction

  function automatic logic [127:0] rpkt(input logic [4:0] kind, input logic [31:0] head,
                                        input logic [10:0] size, input logic [31:0] word);
    return {kind, 3'b000, head, size, word, 45'b0};
  endfunction

  task automatic tick();
    @(posedge nios_clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p);
    bus.packet_in       = p;
    bus.packet_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge nios_clk);
      if (bus.packet_in_ready) begin
        tick();
        bus.packet_in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", {31'b0, bus.packet_in_ready}, 32'd1);
    bus.packet_in_valid = 1'b0;
  endtask

  task automatic cpu(input logic [2:0] op, input logic [31:0] exp);
    bus.clk_en    = 1'b1;
    bus.start     = 1'b1;
    bus.in_opcode = op;
    cpu_q.push_back(exp);
    tick();
    bus.clk_en    = 1'b0;
    bus.start     = 1'b0;
    bus.in_opcode = 3'b000;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (cpu_q.size() == 0 && wr_q.size() == 0) break;
      tick();
    end
    check("cpu_q_left", 32'(cpu_q.size()), 32'd0);
    check("wr_q_left", 32'(wr_q.size()), 32'd0);
  endtask

  always @(negedge nios_clk) begin : cpu_mon
    logic [31:0] e;
    if (!reset) begin
      if (bus.done) begin
        if (cpu_q.size() == 0) begin
          check("done_unexpected", {31'b0, bus.done}, 32'd0);
        end else begin
          e = cpu_q.pop_front();
          check("cpu_result", bus.result, e);
        end
      end else begin
        check("result_idle", bus.result, 32'd0);
      end
    end
  end

  always @(negedge nios_clk) begin : wr_mon
    logic [51:0] w;
    if (!reset && bus.write) begin
      if (bus.waitrequest) begin
        if (stall_seen) begin
          check("stall_addr", 32'(bus.mem_addr), 32'(held_addr));
          check("stall_data", bus.mem_wdata, held_data);
        end
        stall_seen <= 1'b1;
        held_addr  <= bus.mem_addr;
        held_data  <= bus.mem_wdata;
      end else begin
        if (wr_q.size() == 0) begin
          check("write_unexpected", {31'b0, bus.write}, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(w[51:32]));
          check("wr_data", bus.mem_wdata, w[31:0]);
        end
        stall_seen <= 1'b0;
      end
    end else begin
      stall_seen <= 1'b0;
    end
  end

  initial begin
    reset               = 1'b1;
    bus.packet_in       = '0;
    bus.packet_in_valid = 1'b0;
    bus.waitrequest     = 1'b0;
    bus.clk_en          = 1'b0;
    bus.start           = 1'b0;
    bus.in_opcode       = 3'b000;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge nios_clk);
    check("rst_write", {31'b0, bus.write}, 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_ready", {31'b0, bus.packet_in_ready}, 32'd1);
    cpu(3'b010, 32'd0);
    cpu(3'b000, 32'd0);

    // Eager message round trip.
    send(eager(32'h5555_0001, 32'h0000_ABCD));
    cpu(3'b000, 32'h5555_0001);
    cpu(3'b001, 32'h0000_ABCD);
    cpu(3'b010, 32'd0);

    // Rendezvous of three words, second write stalled for two cycles.
    send(rpkt(KRndv, 32'hB000_0001, 11'd3, 32'h0000_0100));
    wr_q.push_back({20'h00100, 32'h11});
    wr_q.push_back({20'h00101, 32'h22});
    wr_q.push_back({20'h00102, 32'h33});
    send(rpkt(KData, 32'h0, 11'd0, 32'h11));
    tick();
    bus.waitrequest = 1'b1;
    send(rpkt(KData, 32'h0, 11'd0, 32'h22));
    tick();
    tick();
    bus.waitrequest = 1'b0;
    send(rpkt(KLast, 32'h0, 11'd0, 32'h33));
    repeat (4) tick();
    cpu(3'b000, 32'hB000_0001);
    cpu(3'b001, 32'd3);
    cpu(3'b010, 32'd0);
    drain();

    // Fill the FIFO; the ninth eager waits for a pop.
    for (int i = 0; i < 8; i++) begin
      send(eager({8'hA0, 8'(i), 16'h0001}, 32'h1000 + 32'(i)));
    end
    bus.packet_in       = eager({8'hA0, 8'd8, 16'h0001}, 32'h1008);
    bus.packet_in_valid = 1'b1;
    @(negedge nios_clk);
    check("ready_full", {31'b0, bus.packet_in_ready}, 32'd0);
    cpu(3'b001, 32'h1000);
    @(negedge nios_clk);
    check("ready_after_pop", {31'b0, bus.packet_in_ready}, 32'd1);
    tick();
    bus.packet_in_valid = 1'b0;
    cpu(3'b010, 32'd8);
    cpu(3'b000, 32'hA001_0001);
    for (int i = 1; i <= 8; i++) begin
      cpu(3'b001, 32'h1000 + 32'(i));
    end
    cpu(3'b010, 32'd0);
    cpu(3'b001, 32'd0);

    // Stray DATA in IDLE, then a short rendezvous ending early.
    send(rpkt(KData, 32'h0, 11'd0, 32'h99));
    send(rpkt(KRndv, 32'hC000_0001, 11'd2, 32'h0000_0200));
    wr_q.push_back({20'h00200, 32'h44});
    send(rpkt(KLast, 32'h0, 11'd0, 32'h44));
    repeat (4) tick();
    cpu(3'b010, 32'h0001_8001);
    cpu(3'b011, 32'd0);
    cpu(3'b010, 32'h0000_0001);
    cpu(3'b000, 32'hC000_0001);
    cpu(3'b001, 32'd2);
    cpu(3'b010, 32'd0);
    cpu(3'b111, 32'd0);
    drain();

    // Destination filtering.
    send(eager(32'hD000_0002, 32'h66));
`ifdef ACC_RECV_DST_CHECK_EN
    cpu(3'b010, 32'h0001_0000);
`else
    cpu(3'b010, 32'h0000_0001);
    cpu(3'b001, 32'h66);
`endif
    send(eager(32'hD000_0001, 32'h77));
    cpu(3'b001, 32'h77);
    cpu(3'b011, 32'd0);
    drain();

    // Reset while a write is stalled.
    send(rpkt(KRndv, 32'hE000_0001, 11'd4, 32'h0000_0300));
    bus.waitrequest = 1'b1;
    send(rpkt(KData, 32'h0, 11'd0, 32'h55));
    @(negedge nios_clk);
    check("wr_before_rst", {31'b0, bus.write}, 32'd1);
    check("wr_addr_before_rst", 32'(bus.mem_addr), 32'h300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.waitrequest = 1'b0;
    @(negedge nios_clk);
    check("post_rst_write", {31'b0, bus.write}, 32'd0);
    check("post_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("post_rst_wdata", bus.mem_wdata, 32'd0);
    check("post_rst_done", {31'b0, bus.done}, 32'd0);
    check("post_rst_result", bus.result, 32'd0);
    cpu(3'b010, 32'd0);
    cpu(3'b000, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
